// File: rtl/seq_16_bit_subtractor_pkg.sv
// ============================================================================
// Module : seq_16_bit_subtractor_pkg
// Brief  : Shared state encoding and size defaults for the sequential subtractor
// Rev    : 1.0
// ============================================================================
`default_nettype none

package seq_16_bit_subtractor_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_SLICE = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/seq_16_bit_subtractor_slice.sv
// ============================================================================
// Module : slice_subtractor
// Brief  : Combinational SLICE-bit subtract with borrow, plus borrow into MSB
// Rev    : 1.0
// ============================================================================
`default_nettype none

module slice_subtractor #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             bin,
  output logic [SLICE-1:0] d,
  output logic             bout,
  output logic             bmsb
);

  logic [SLICE:0]   full;
  logic [SLICE-1:0] low;

  assign full = {1'b0, a} - {1'b0, b} - {{SLICE{1'b0}}, bin};
  // Subtracting only the bits below the MSB exposes the borrow into the MSB
  assign low  = {1'b0, a[SLICE-2:0]} - {1'b0, b[SLICE-2:0]} - {{(SLICE-1){1'b0}}, bin};

  assign d    = full[SLICE-1:0];
  assign bout = full[SLICE];
  assign bmsb = low[SLICE-1];

endmodule

`default_nettype wire

// File: rtl/seq_16_bit_subtractor.sv
// ============================================================================
// Module : seq_16_bit_subtractor
// Brief  : Multi-cycle a - b - borrow_in, one slice per cycle, start/done handshake
// Rev    : 1.0
// ============================================================================
`default_nettype none

module seq_16_bit_subtractor
  import seq_16_bit_subtractor_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] input_a,
  input  logic [WIDTH-1:0] input_b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int NSLICES = WIDTH / SLICE;
  localparam int IDX_W   = (NSLICES > 1) ? $clog2(NSLICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICES - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] work;
  logic             br;

  logic [SLICE-1:0] slice_a;
  logic [SLICE-1:0] slice_b;
  logic [SLICE-1:0] slice_d;
  logic             slice_bout;
  logic             slice_bmsb;
  logic [WIDTH-1:0] result;

  assign slice_a = op_a[idx*SLICE +: SLICE];
  assign slice_b = op_b[idx*SLICE +: SLICE];

  slice_subtractor #(
    .SLICE (SLICE)
  ) u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .bin  (br),
    .d    (slice_d),
    .bout (slice_bout),
    .bmsb (slice_bmsb)
  );

  // Final slice is merged here so diff can load the complete word on the DONE edge
  always_comb begin
    result = work;
    result[idx*SLICE +: SLICE] = slice_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      idx        <= '0;
      op_a       <= '0;
      op_b       <= '0;
      work       <= '0;
      br         <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state <= ST_CALC;
            busy  <= 1'b1;
            op_a  <= input_a;
            op_b  <= input_b;
            br    <= borrow_in;
            idx   <= '0;
            work  <= '0;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_CALC: begin
          work[idx*SLICE +: SLICE] <= slice_d;
          br <= slice_bout;
          if (idx == LAST_IDX) begin
            state      <= ST_DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
            diff       <= result;
            borrow_out <= slice_bout;
            overflow   <= slice_bmsb ^ slice_bout;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seq_16_bit_subtractor.sv
// ============================================================================
// Module : tb_seq_16_bit_subtractor
// Brief  : Directed vector table plus handshake corner-case sequences
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_seq_16_bit_subtractor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] input_a = '0;
  logic [15:0] input_b = '0;
  logic        borrow_in = 1'b0;
  logic        busy;
  logic        done;
  logic [15:0] diff;
  logic        borrow_out;
  logic        overflow;

  int passed = 0;
  int total  = 0;

  seq_16_bit_subtractor dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .input_a    (input_a),
    .input_b    (input_b),
    .borrow_in  (borrow_in),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] d;
    logic        bo;
    logic        ov;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands with start; the following edge accepts them
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic bin);
    input_a   = a;
    input_b   = b;
    borrow_in = bin;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    input_a   = 16'($urandom);
    input_b   = 16'($urandom);
    borrow_in = 1'($urandom);
  endtask

  // n0 = edges already elapsed since the accepting edge
  task automatic wait_done(input string name, input int n0, input logic [15:0] ed,
                           input logic eb, input logic eo);
    int n;
    n = n0;
    while (!done && n < 10) begin
      chk({name, "_busy"}, {31'd0, busy}, 32'd1);
      tick();
      n++;
    end
    chk({name, "_latency"}, n, 32'd4);
    chk({name, "_done"}, {31'd0, done}, 32'd1);
    chk({name, "_busy_low"}, {31'd0, busy}, 32'd0);
    chk({name, "_diff"}, {16'd0, diff}, {16'd0, ed});
    chk({name, "_borrow"}, {31'd0, borrow_out}, {31'd0, eb});
    chk({name, "_ovf"}, {31'd0, overflow}, {31'd0, eo});
  endtask

  initial begin
    vecs[0] = '{a: 16'd3237,   b: 16'd1172,  bin: 1'b1, d: 16'd2064,   bo: 1'b0, ov: 1'b0};
    vecs[1] = '{a: 16'd12,     b: 16'd2434,  bin: 1'b0, d: 16'hF68A,   bo: 1'b1, ov: 1'b0};
    vecs[2] = '{a: 16'h8000,   b: 16'h0001,  bin: 1'b0, d: 16'h7FFF,   bo: 1'b0, ov: 1'b1};
    vecs[3] = '{a: 16'h0000,   b: 16'h0000,  bin: 1'b1, d: 16'hFFFF,   bo: 1'b1, ov: 1'b0};
    vecs[4] = '{a: 16'h7FFF,   b: 16'hFFFF,  bin: 1'b0, d: 16'h8000,   bo: 1'b1, ov: 1'b1};

    rst = 1'b1;
    repeat (3) tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_diff", {16'd0, diff}, 32'd0);
    chk("rst_borrow", {31'd0, borrow_out}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].bin);
      wait_done($sformatf("vec%0d", i), 0, vecs[i].d, vecs[i].bo, vecs[i].ov);
      tick();
      chk($sformatf("vec%0d_pulse", i), {31'd0, done}, 32'd0);
      tick();
    end

    // start during CALC is ignored; diff holds the previous result meanwhile
    issue(16'd3237, 16'd1172, 1'b1);
    tick();
    chk("ign_hold_diff", {16'd0, diff}, {16'd0, 16'h8000});
    input_a = 16'd1; input_b = 16'd1; borrow_in = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("ign", 2, 16'd2064, 1'b0, 1'b0);

    // start held in the DONE cycle is accepted back-to-back
    issue(16'd6431, 16'd3000, 1'b1);
    chk("b2b_done_low", {31'd0, done}, 32'd0);
    wait_done("b2b", 0, 16'd3430, 1'b0, 1'b0);
    tick();
    begin
      int extra;
      extra = 0;
      repeat (6) begin
        if (done) extra++;
        tick();
      end
      chk("b2b_no_extra_done", extra, 32'd0);
    end

    // reset in the second CALC cycle aborts the operation
    issue(16'd3237, 16'd1172, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_diff", {16'd0, diff}, 32'd0);
    chk("abort_borrow", {31'd0, borrow_out}, 32'd0);
    chk("abort_ovf", {31'd0, overflow}, 32'd0);
    begin
      int seen;
      seen = 0;
      repeat (6) begin
        tick();
        if (done || busy) seen++;
      end
      chk("abort_quiet", seen, 32'd0);
    end
    issue(16'd122, 16'd61421, 1'b0);
    wait_done("post_rst", 0, 16'd4237, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
